// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: walks the PC through an instruction ROM,
// honouring run control, downstream stalls, ROM wait states and redirects.
module fetch_ctrl #(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            stall_i,
  input  logic            jump_en_i,
  input  logic [PC_W-1:0] jump_addr_i,
  input  logic            mem_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic            ce_o,
  output logic            inst_valid_o,
  output logic            flush_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic            flush_q, flush_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      flush_q <= flush_n;
    end
  end

  // Priority inside FETCH: run control, redirect, stall, then ROM accept.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    flush_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_n = FETCH;
      end
      FETCH: begin
        if (!enable_i) begin
          state_n = IDLE;
        end else if (jump_en_i) begin
          pc_n    = jump_addr_i;
          flush_n = 1'b1;
        end else if (stall_i) begin
          state_n = STALL;
        end else if (mem_ready_i) begin
          pc_n = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      STALL: begin
        if (!enable_i) begin
          state_n = IDLE;
        end else if (jump_en_i) begin
          pc_n    = jump_addr_i;
          flush_n = 1'b1;
          state_n = FETCH;
        end else if (!stall_i) begin
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pc_o         = pc_q;
  assign flush_o      = flush_q;
  assign ce_o         = (state_q == FETCH);
  // Acceptance is exactly the increment branch of FETCH.
  assign inst_valid_o = (state_q == FETCH) && enable_i && !jump_en_i &&
                        !stall_i && mem_ready_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues the expected outputs of
// each cycle it drives; a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  localparam int PC_W = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            stall = 1'b0;
  logic            jump_en = 1'b0;
  logic [PC_W-1:0] jump_addr = '0;
  logic            mem_ready = 1'b0;
  logic [PC_W-1:0] pc;
  logic            ce;
  logic            inst_valid;
  logic            flush;
  logic [1:0]      state;

  int checks = 0;
  int failures = 0;
  int cyc_idx = 0;
  logic [PC_W+2:0] exp_q[$];

  fetch_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .stall_i(stall),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .mem_ready_i(mem_ready),
    .pc_o(pc), .ce_o(ce), .inst_valid_o(inst_valid), .flush_o(flush),
    .state_o(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the edge and queue its expected outputs.
  task automatic cyc(input logic r, input logic en, input logic st,
                     input logic jp, input logic [PC_W-1:0] ja,
                     input logic mr, input logic [PC_W-1:0] epc,
                     input logic ece, input logic ev, input logic ef);
    @(posedge clk);
    #1;
    rst = r; enable = en; stall = st; jump_en = jp; jump_addr = ja;
    mem_ready = mr;
    exp_q.push_back({epc, ece, ev, ef});
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [PC_W+2:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({pc, ce, inst_valid, flush} !== e) begin
        failures++;
        $display("FAIL cyc%0d: got pc=%0d ce=%b valid=%b flush=%b, want pc=%0d ce=%b valid=%b flush=%b",
                 cyc_idx, pc, ce, inst_valid, flush,
                 e[PC_W+2:3], e[2], e[1], e[0]);
      end
      cyc_idx++;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got no end of stimulus, want finish before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    //  rst en st jp addr mr | pc ce v f
    cyc(1, 0, 0, 0, 0,  0,  0, 0, 0, 0);   // held in reset
    cyc(0, 1, 0, 0, 0,  1,  0, 0, 0, 0);   // first cycle after release is IDLE
    cyc(0, 1, 0, 0, 0,  1,  0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  2, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  3, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  4, 1, 1, 0);
    // stall at pc 5 for three cycles, then re-fetch 5
    cyc(0, 1, 1, 0, 0,  1,  5, 1, 0, 0);
    cyc(0, 1, 1, 0, 0,  1,  5, 0, 0, 0);
    cyc(0, 1, 1, 0, 0,  1,  5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  5, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  6, 1, 1, 0);
    // redirect beats stall and ready at pc 7
    cyc(0, 1, 1, 1, 40, 1,  7, 1, 0, 0);
    cyc(0, 1, 0, 0, 0,  1, 40, 1, 1, 1);
    // redirect to own pc, then back-to-back redirect
    cyc(0, 1, 0, 1, 41, 1, 41, 1, 0, 0);
    cyc(0, 1, 0, 1, 10, 1, 41, 1, 0, 1);
    // ROM wait states at pc 10
    cyc(0, 1, 0, 0, 0,  0, 10, 1, 0, 1);
    cyc(0, 1, 0, 0, 0,  0, 10, 1, 0, 0);
    cyc(0, 1, 0, 0, 0,  0, 10, 1, 0, 0);
    cyc(0, 1, 0, 0, 0,  0, 10, 1, 0, 0);
    cyc(0, 1, 0, 0, 0,  1, 10, 1, 1, 0);
    // wrap 63 -> 0
    cyc(0, 1, 0, 1, 62, 1, 11, 1, 0, 0);
    cyc(0, 1, 0, 0, 0,  1, 62, 1, 1, 1);
    cyc(0, 1, 0, 0, 0,  1, 63, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  0, 1, 1, 0);
    // disable from FETCH, redirect ignored in IDLE, re-enable
    cyc(0, 0, 0, 0, 0,  1,  1, 1, 0, 0);
    cyc(0, 0, 0, 1, 33, 1,  1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  1, 1, 1, 0);
    // redirect taken from STALL, then stall again at pc 20
    cyc(0, 1, 1, 0, 0,  1,  2, 1, 0, 0);
    cyc(0, 1, 1, 1, 20, 1,  2, 0, 0, 0);
    cyc(0, 1, 1, 0, 0,  1, 20, 1, 0, 1);
    cyc(0, 1, 1, 0, 0,  1, 20, 0, 0, 0);

    // asynchronous reset mid-stall, checked before any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 6'd0 || ce !== 1'b0 || inst_valid !== 1'b0 || flush !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: got pc=%0d ce=%b valid=%b flush=%b, want pc=0 ce=0 valid=0 flush=0",
               pc, ce, inst_valid, flush);
    end
    cyc(1, 1, 1, 0, 0,  1,  0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0,  1,  0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0,  1,  1, 1, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 6, program-counter and jump-address width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 enable_i  input  1  run control; 0 parks the fetch unit in IDLE.
REQ-006 stall_i  input  1  downstream not ready; 1 blocks instruction acceptance.
REQ-007 jump_en_i  input  1  redirect request, sampled each cycle.
REQ-008 jump_addr_i  input  PC_W  redirect target.
REQ-009 mem_ready_i  input  1  instruction ROM data for pc_o is valid this cycle.
REQ-010 pc_o  output  PC_W  current fetch address, registered.
REQ-011 ce_o  output  1  instruction ROM chip enable.
REQ-012 inst_valid_o  output  1  instruction at pc_o is accepted downstream this cycle.
REQ-013 flush_o  output  1  registered one-cycle pulse following an accepted redirect.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FETCH, STALL.
REQ-015 ce_o SHALL equal 1 only in FETCH, decoded from the state register, with no input term.
REQ-016 IDLE: ce_o=0, pc_o held; enable_i=1 -> FETCH next cycle; jump_en_i ignored.
REQ-017 FETCH, priority 1: enable_i=0 -> IDLE, pc_o held.
REQ-018 FETCH, priority 2: jump_en_i=1 -> pc_o<=jump_addr_i, flush_o<=1, remain FETCH.
REQ-019 FETCH, priority 3: stall_i=1 -> STALL, pc_o held.
REQ-020 FETCH, priority 4: mem_ready_i=1 -> pc_o<=pc_o+1, remain FETCH.
REQ-021 FETCH, none of the above: remain FETCH, pc_o held (ROM wait state, unbounded).
REQ-022 STALL: ce_o=0; enable_i=0 -> IDLE; else jump_en_i=1 -> pc_o<=jump_addr_i, flush_o<=1, FETCH; else stall_i=0 -> FETCH, pc_o held; else remain STALL.
REQ-023 inst_valid_o SHALL be combinational: state==FETCH and enable_i and !jump_en_i and !stall_i and mem_ready_i; it SHALL be 1 exactly in cycles where REQ-020 fires.
REQ-024 An instruction present on a stalled FETCH cycle SHALL NOT be accepted; the same pc_o SHALL be re-fetched after STALL exits (minimum one cycle with ce_o=0).
REQ-025 PC increment SHALL wrap modulo 2^PC_W (all-ones + 1 -> 0) with no flag.
REQ-026 flush_o SHALL be 1 only in the cycle immediately after a redirect is taken in FETCH or STALL, otherwise 0; back-to-back redirects yield back-to-back pulses.
REQ-027 A redirect to the current pc_o value SHALL still pulse flush_o.

Reset
REQ-028 While rst_i=1, regardless of the clock: state=IDLE, pc_o=RESET_PC, ce_o=0, flush_o=0, inst_valid_o=0.
REQ-029 Reset asserted in any state, including mid-wait or mid-stall, SHALL discard all progress; no pending redirect survives.
REQ-030 After rst_i deasserts with enable_i=1, the first cycle SHALL be IDLE (ce_o=0); FETCH with ce_o=1 begins on the following edge.

Verification
REQ-031 Reset then enable_i=1, mem_ready_i=1, stall_i=0 -> ce_o rises one cycle after release; pc_o goes 0,1,2,3 on consecutive cycles; inst_valid_o=1 every cycle in FETCH.
REQ-032 PC_W=6 at pc_o=63 with accept -> pc_o=0 next cycle, no other effect.
REQ-033 At pc_o=5 in FETCH, assert stall_i for 3 cycles with mem_ready_i=1 -> inst_valid_o=0, STALL with ce_o=0; after release, FETCH at pc_o=5, then accept 5 -> pc_o=6.
REQ-034 Same cycle jump_en_i=1 (addr 40), stall_i=1, mem_ready_i=1 at pc_o=7 -> pc_o=40, flush_o=1 next cycle, state FETCH, inst_valid_o=0 that cycle.
REQ-035 mem_ready_i=0 for 4 cycles at pc_o=10 -> pc_o stays 10, ce_o=1, inst_valid_o=0; accept on first mem_ready_i=1 -> pc_o=11.
REQ-036 rst_i pulsed asynchronously mid-stall at pc_o=20 -> pc_o=RESET_PC and ce_o=0 immediately, before the next clock edge.
